// File: rtl/gemm_tile_sequencer_pkg.sv
// rtl/gemm_tile_sequencer_pkg.sv - shared state encoding and timing constants for the GEMM tile sequencer
package gemm_tile_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_WAIT_ARR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // Weight load: one read per row plus one cycle for the last row to land.
  function automatic int unsigned load_len(input int unsigned array_size);
    return array_size + 1;
  endfunction

  // Zero-padded vectors needed to push the last activation through the skewed array.
  function automatic int unsigned flush_len(input int unsigned array_size);
    return 2 * array_size - 2;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned array_size, input int unsigned timeout);
    int unsigned span;
    span = 3 * array_size;
    if (timeout + 1 > span) span = timeout + 1;
    return $clog2(span + 1);
  endfunction

endpackage

// File: rtl/gemm_tile_sequencer_if.sv
// rtl/gemm_tile_sequencer_if.sv - tile command channel between host and sequencer
interface gemm_tile_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned NV_WIDTH   = 5
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_wgt_base;
  logic [ADDR_WIDTH-1:0] cmd_act_base;
  logic [ADDR_WIDTH-1:0] cmd_out_base;
  logic [NV_WIDTH-1:0]   cmd_num_vecs;
  logic                  cmd_accumulate;

  modport master (
    output cmd_valid, cmd_wgt_base, cmd_act_base, cmd_out_base, cmd_num_vecs, cmd_accumulate,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_wgt_base, cmd_act_base, cmd_out_base, cmd_num_vecs, cmd_accumulate,
    output cmd_ready
  );
endinterface

// File: rtl/sram_rd_align.sv
// rtl/sram_rd_align.sv - delays a read strobe and its tag by the 1-cycle SRAM read latency
module sram_rd_align #(
  parameter int unsigned TAG_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
    end else begin
      out_valid <= rd_en;
      out_tag   <= rd_en ? rd_tag : '0;
    end
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// rtl/gemm_tile_sequencer.sv - sequences weight load, activation stream and drain for one systolic tile
module gemm_tile_sequencer
  import gemm_tile_sequencer_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  gemm_tile_sequencer_if.slave          cmd,
  output logic                          wgt_rd_en,
  output logic [ADDR_WIDTH-1:0]         wgt_rd_addr,
  output logic                          act_rd_en,
  output logic [ADDR_WIDTH-1:0]         act_rd_addr,
  output logic                          sa_load_weights,
  output logic                          sa_start_compute,
  output logic                          sa_clear_acc,
  output logic                          sa_activation_valid,
  output logic                          sa_act_zero,
  output logic [$clog2(ARRAY_SIZE)-1:0] sa_weight_row,
  input  logic                          sa_busy,
  input  logic                          sa_result_valid,
  output logic                          res_wr_en,
  output logic [ADDR_WIDTH-1:0]         res_wr_addr,
  output logic                          done,
  output logic                          err,
  output logic                          busy
);

  localparam int unsigned NVW = $clog2(ARRAY_SIZE) + 1;
  localparam int unsigned RW  = $clog2(ARRAY_SIZE);
  localparam int unsigned CW  = cnt_width(ARRAY_SIZE, TIMEOUT);
  localparam logic [CW-1:0] LOAD_LAST = CW'(load_len(ARRAY_SIZE) - 1);
  localparam logic [CW-1:0] ROWS      = CW'(ARRAY_SIZE);
  localparam logic [CW-1:0] FLUSH     = CW'(flush_len(ARRAY_SIZE));
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  seq_state_e            state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_inc;
  logic [CW-1:0]         stream_len;
  logic [NVW-1:0]        num_vecs;
  logic                  accumulate;
  logic [ADDR_WIDTH-1:0] act_base;
  logic [ADDR_WIDTH-1:0] res_ptr;
  logic                  err_flag;
  logic                  feed_en;
  logic                  nv_ok;
  logic [RW-1:0]         wgt_row;
  logic                  act_zero_tag;

  assign cnt_inc      = cnt + CW'(1);
  assign stream_len   = CW'(num_vecs) + FLUSH;
  assign nv_ok        = (cmd.cmd_num_vecs != '0) && (cmd.cmd_num_vecs <= NVW'(ARRAY_SIZE));
  assign wgt_row      = cnt[RW-1:0];
  // Feeder slots past the real vectors carry zeros to flush the skew.
  assign act_zero_tag = feed_en & ~act_rd_en;

  sram_rd_align #(.TAG_W(RW)) u_wgt_align (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (wgt_rd_en),
    .rd_tag    (wgt_row),
    .out_valid (sa_load_weights),
    .out_tag   (sa_weight_row)
  );

  sram_rd_align #(.TAG_W(1)) u_act_align (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (feed_en),
    .rd_tag    (act_zero_tag),
    .out_valid (sa_activation_valid),
    .out_tag   (sa_act_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      num_vecs         <= '0;
      accumulate       <= 1'b0;
      act_base         <= '0;
      res_ptr          <= '0;
      err_flag         <= 1'b0;
      feed_en          <= 1'b0;
      cmd.cmd_ready    <= 1'b0;
      wgt_rd_en        <= 1'b0;
      wgt_rd_addr      <= '0;
      act_rd_en        <= 1'b0;
      act_rd_addr      <= '0;
      sa_start_compute <= 1'b0;
      sa_clear_acc     <= 1'b0;
      res_wr_en        <= 1'b0;
      res_wr_addr      <= '0;
      done             <= 1'b0;
      err              <= 1'b0;
      busy             <= 1'b0;
    end else begin
      sa_start_compute <= 1'b0;
      sa_clear_acc     <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      res_wr_en        <= sa_result_valid;
      if (sa_result_valid) begin
        res_wr_addr <= res_ptr;
        res_ptr     <= res_ptr + ADDR_WIDTH'(1);
      end
      case (state)
        ST_IDLE: begin
          cmd.cmd_ready <= 1'b1;
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            cmd.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            state         <= ST_LOAD_W;
            cnt           <= '0;
            num_vecs      <= cmd.cmd_num_vecs;
            accumulate    <= cmd.cmd_accumulate;
            act_base      <= cmd.cmd_act_base;
            res_ptr       <= cmd.cmd_out_base;
            err_flag      <= !nv_ok;
            wgt_rd_en     <= nv_ok;
            wgt_rd_addr   <= cmd.cmd_wgt_base;
          end
        end
        ST_LOAD_W: begin
          if (err_flag) begin
            state <= ST_DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (cnt == LOAD_LAST) begin
            state <= ST_WAIT_ARR;
            cnt   <= '0;
          end else begin
            cnt       <= cnt_inc;
            wgt_rd_en <= (cnt_inc < ROWS);
            if (wgt_rd_en) wgt_rd_addr <= wgt_rd_addr + ADDR_WIDTH'(1);
          end
        end
        ST_WAIT_ARR: begin
          if (!sa_busy) begin
            state            <= ST_STREAM;
            cnt              <= '0;
            sa_start_compute <= 1'b1;
            sa_clear_acc     <= !accumulate;
            act_rd_en        <= 1'b1;
            act_rd_addr      <= act_base;
            feed_en          <= 1'b1;
          end
        end
        ST_STREAM: begin
          cnt       <= cnt_inc;
          act_rd_en <= (cnt_inc < CW'(num_vecs));
          feed_en   <= (cnt_inc < stream_len);
          if (act_rd_en) act_rd_addr <= act_rd_addr + ADDR_WIDTH'(1);
          if (cnt == stream_len) begin
            state <= ST_DRAIN;
            cnt   <= '0;
          end
        end
        ST_DRAIN: begin
          if (!sa_busy && !sa_result_valid) begin
            state <= ST_DONE;
            done  <= 1'b1;
            err   <= err_flag;
          end else if (cnt >= TIMEOUT_C) begin
            state <= ST_DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt_inc;
          end
        end
        ST_DONE: begin
          state         <= ST_IDLE;
          cnt           <= '0;
          err_flag      <= 1'b0;
          busy          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
